// File: rtl/icache_fetch_port.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the
// instruction fetcher and the memory controller. Hits return in one cycle;
// misses issue a single word refill. A flush during a refill still lets the
// refill land in the array but drops its delivery to the fetcher.
module icache_fetch_port #(
    parameter int unsigned INDEX_BITS    = 6,
    parameter logic [31:0] RESET_PC_HINT = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _fetch_valid,
    input  logic [31:0] _fetch_pc,
    output logic        _inst_ready,
    output logic [31:0] _inst_out,
    output logic        _busy,
    output logic        _mem_req,
    output logic [31:0] _mem_addr,
    input  logic        _mem_ack,
    input  logic [31:0] _mem_data
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        ABORT  = 2'd2
    } state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit_c;
    logic                  fill_c;
    logic                  unused_bits;

    // Lookup fields come from the live fetch PC; refill fields come from the
    // held refill address, which doubles as the latched miss PC.
    assign req_index  = _fetch_pc[INDEX_BITS+1:2];
    assign req_tag    = _fetch_pc[31:INDEX_BITS+2];
    assign fill_index = _mem_addr[INDEX_BITS+1:2];
    assign fill_tag   = _mem_addr[31:INDEX_BITS+2];
    assign hit_c      = valid[req_index] && (tag_mem[req_index] == req_tag);
    // An ack only counts while a request is outstanding (REFILL or ABORT).
    assign fill_c     = (state != IDLE) && _mem_ack;

    // Byte-offset bits and the start-address hint carry no logic.
    assign unused_bits = ^{_fetch_pc[1:0], _mem_addr[1:0], RESET_PC_HINT};

    // Tag/data array write on a completed refill; contents need no reset.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && fill_c) begin
            data_mem[fill_index] <= _mem_data;
            tag_mem[fill_index]  <= fill_tag;
        end
    end

    // Control FSM with registered outputs and valid bits.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            valid       <= '0;
            _inst_ready <= 1'b0;
            _inst_out   <= 32'h0;
            _busy       <= 1'b0;
            _mem_req    <= 1'b0;
            _mem_addr   <= 32'h0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    _inst_ready <= 1'b0;
                    if (_fetch_valid && !_clear) begin
                        if (hit_c) begin
                            _inst_ready <= 1'b1;
                            _inst_out   <= data_mem[req_index];
                        end else begin
                            state     <= REFILL;
                            _busy     <= 1'b1;
                            _mem_req  <= 1'b1;
                            _mem_addr <= {_fetch_pc[31:2], 2'b00};
                        end
                    end
                end
                REFILL: begin
                    _inst_ready <= 1'b0;
                    if (_mem_ack) begin
                        valid[fill_index] <= 1'b1;
                        state    <= IDLE;
                        _busy    <= 1'b0;
                        _mem_req <= 1'b0;
                        if (!_clear) begin
                            _inst_ready <= 1'b1;
                            _inst_out   <= _mem_data;
                        end
                    end else if (_clear) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    _inst_ready <= 1'b0;
                    if (_mem_ack) begin
                        valid[fill_index] <= 1'b1;
                        state    <= IDLE;
                        _busy    <= 1'b0;
                        _mem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    _inst_ready <= 1'b0;
                    _busy       <= 1'b0;
                    _mem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_port.sv
// Directed bench for icache_fetch_port: expected instruction words are queued
// when a fetch/refill is driven and popped whenever the cache pulses ready.
module tb_icache_fetch_port;

    logic        clk_in       = 1'b0;
    logic        rst_in       = 1'b0;
    logic        rdy_in       = 1'b1;
    logic        _clear       = 1'b0;
    logic        _fetch_valid = 1'b0;
    logic [31:0] _fetch_pc    = 32'h0;
    logic        _inst_ready;
    logic [31:0] _inst_out;
    logic        _busy;
    logic        _mem_req;
    logic [31:0] _mem_addr;
    logic        _mem_ack     = 1'b0;
    logic [31:0] _mem_data    = 32'h0;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic        last_ready;

    icache_fetch_port #(.INDEX_BITS(6), .RESET_PC_HINT(32'h0)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        ._clear       (_clear),
        ._fetch_valid (_fetch_valid),
        ._fetch_pc    (_fetch_pc),
        ._inst_ready  (_inst_ready),
        ._inst_out    (_inst_out),
        ._busy        (_busy),
        ._mem_req     (_mem_req),
        ._mem_addr    (_mem_addr),
        ._mem_ack     (_mem_ack),
        ._mem_data    (_mem_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later, and score any ready pulse.
    task automatic step();
        @(posedge clk_in);
        #1;
        last_ready = _inst_ready;
        if (_inst_ready === 1'b1) begin
            if (exp_q.size() > 0) chk("inst_out", _inst_out, exp_q.pop_front());
            else chk("spurious_ready", 32'(_inst_ready), 32'd0);
        end
    endtask

    task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] data, input int gap);
        _fetch_valid = 1'b1;
        _fetch_pc    = pc;
        step();
        chk("miss_req", 32'(_mem_req), 32'd1);
        chk("miss_addr", _mem_addr, {pc[31:2], 2'b00});
        chk("miss_busy", 32'(_busy), 32'd1);
        for (int i = 0; i < gap; i++) begin
            step();
            chk("req_held", 32'(_mem_req), 32'd1);
            chk("addr_held", _mem_addr, {pc[31:2], 2'b00});
        end
        _fetch_valid = 1'b0;
        _mem_ack     = 1'b1;
        _mem_data    = data;
        exp_q.push_back(data);
        step();
        _mem_ack = 1'b0;
        chk("fill_ready", 32'(last_ready), 32'd1);
        chk("fill_req_drop", 32'(_mem_req), 32'd0);
        chk("fill_busy_drop", 32'(_busy), 32'd0);
    endtask

    task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] data);
        _fetch_valid = 1'b1;
        _fetch_pc    = pc;
        exp_q.push_back(data);
        step();
        _fetch_valid = 1'b0;
        chk("hit_ready", 32'(last_ready), 32'd1);
        chk("hit_no_req", 32'(_mem_req), 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ready", 32'(_inst_ready), 32'd0);
        chk("rst_out", _inst_out, 32'h0);
        chk("rst_req", 32'(_mem_req), 32'd0);
        chk("rst_addr", _mem_addr, 32'h0);
        chk("rst_busy", 32'(_busy), 32'd0);
        rst_in = 1'b1;
        step();

        // Cold miss at 0x0, ack after three request cycles
        fetch_miss(32'h0000_0000, 32'h0000_0013, 2);

        // Hit on refetch, then fill 0x4 and stream 0x4, 0x0 back to back
        fetch_hit(32'h0000_0000, 32'h0000_0013);
        fetch_miss(32'h0000_0004, 32'h0010_0093, 0);
        _fetch_valid = 1'b1;
        _fetch_pc    = 32'h0000_0004;
        exp_q.push_back(32'h0010_0093);
        step();
        chk("b2b_first", 32'(last_ready), 32'd1);
        _fetch_pc = 32'h0000_0000;
        exp_q.push_back(32'h0000_0013);
        step();
        chk("b2b_second", 32'(last_ready), 32'd1);
        chk("b2b_no_req", 32'(_mem_req), 32'd0);
        _fetch_valid = 1'b0;
        step();
        chk("idle_no_ready", 32'(last_ready), 32'd0);

        // Stray ack in IDLE is ignored
        _mem_ack  = 1'b1;
        _mem_data = 32'hFFFF_FFFF;
        step();
        _mem_ack = 1'b0;
        chk("stray_ack_req", 32'(_mem_req), 32'd0);
        chk("stray_ack_busy", 32'(_busy), 32'd0);

        // Flush in IDLE suppresses a would-be hit
        _fetch_valid = 1'b1;
        _fetch_pc    = 32'h0000_0000;
        _clear       = 1'b1;
        step();
        _clear       = 1'b0;
        _fetch_valid = 1'b0;
        chk("idle_clear_ready", 32'(last_ready), 32'd0);
        chk("idle_clear_req", 32'(_mem_req), 32'd0);
        fetch_hit(32'h0000_0000, 32'h0000_0013);

        // Conflict eviction at index 0
        fetch_miss(32'h0000_0100, 32'hDEAD_BEEF, 1);
        fetch_hit(32'h0000_0100, 32'hDEAD_BEEF);
        fetch_miss(32'h0000_0000, 32'h0000_0013, 0);

        // Flush one cycle into a refill of 0x40
        _fetch_valid = 1'b1;
        _fetch_pc    = 32'h0000_0040;
        step();
        _fetch_valid = 1'b0;
        chk("abort_req", 32'(_mem_req), 32'd1);
        chk("abort_addr", _mem_addr, 32'h0000_0040);
        _clear = 1'b1;
        step();
        _clear = 1'b0;
        chk("abort_req_held", 32'(_mem_req), 32'd1);
        chk("abort_busy", 32'(_busy), 32'd1);
        _clear = 1'b1;
        step();
        _clear = 1'b0;
        chk("abort_req_held2", 32'(_mem_req), 32'd1);
        _mem_ack  = 1'b1;
        _mem_data = 32'h1234_5678;
        step();
        _mem_ack = 1'b0;
        chk("abort_no_ready", 32'(last_ready), 32'd0);
        chk("abort_req_drop", 32'(_mem_req), 32'd0);
        chk("abort_busy_drop", 32'(_busy), 32'd0);
        fetch_hit(32'h0000_0040, 32'h1234_5678);
        fetch_hit(32'h0000_0043, 32'h1234_5678);

        // Flush and ack in the same cycle: line filled, nothing delivered
        _fetch_valid = 1'b1;
        _fetch_pc    = 32'h0000_0080;
        step();
        _fetch_valid = 1'b0;
        _clear       = 1'b1;
        _mem_ack     = 1'b1;
        _mem_data    = 32'hCAFE_F00D;
        step();
        _clear   = 1'b0;
        _mem_ack = 1'b0;
        chk("clr_ack_ready", 32'(last_ready), 32'd0);
        chk("clr_ack_busy", 32'(_busy), 32'd0);
        fetch_hit(32'h0000_0080, 32'hCAFE_F00D);

        // Global stall during a refill
        _fetch_valid = 1'b1;
        _fetch_pc    = 32'h0000_00C0;
        step();
        _fetch_valid = 1'b0;
        rdy_in       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_req", 32'(_mem_req), 32'd1);
            chk("stall_addr", _mem_addr, 32'h0000_00C0);
            chk("stall_busy", 32'(_busy), 32'd1);
        end
        rdy_in    = 1'b1;
        _mem_ack  = 1'b1;
        _mem_data = 32'h0BAD_CAFE;
        exp_q.push_back(32'h0BAD_CAFE);
        step();
        _mem_ack = 1'b0;
        chk("stall_resume_ready", 32'(last_ready), 32'd1);
        chk("stall_resume_req", 32'(_mem_req), 32'd0);

        // Reset in the middle of a refill
        _fetch_valid = 1'b1;
        _fetch_pc    = 32'h0000_0200;
        step();
        _fetch_valid = 1'b0;
        chk("pre_rst_req", 32'(_mem_req), 32'd1);
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        chk("mid_rst_req", 32'(_mem_req), 32'd0);
        chk("mid_rst_ready", 32'(_inst_ready), 32'd0);
        chk("mid_rst_busy", 32'(_busy), 32'd0);
        fetch_miss(32'h0000_0040, 32'h1234_5678, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
